mat_bias_relu: RTL and testbench
================================

// Module: mat_bias_relu
// PURPOSE
//  Downstream neighbour of mat_product in an NN layer. Accepts an MxP float32 product matrix and a
//  P-entry float32 bias row vector, adds bias[j] to every element of column j, optionally applies ReLU,
//  and presents the MxP result. One shared float32 adder is used serially. All ports use stb/ack handshakes.
// PARAMETERS
//  M     2  rows of input/output matrix (>=1)
//  P     2  columns of input/output matrix, and length of bias (>=1)
//  RELU  1  1: negative results (sign bit set) are replaced by +0 (32'h00000000); 0: pass-through
// PORTS
//  clk             in   1          single clock, rising edge
//  rst             in   1          asynchronous, active-high reset
//  input_z         in   [M][P][32] product matrix from mat_product (row-major packed, [i][j])
//  input_z_stb     in   1          input_z valid
//  input_z_ack     out  1          input_z accepted in a cycle where input_z_stb && input_z_ack
//  input_bias      in   [P][32]    bias vector
//  input_bias_stb  in   1          input_bias valid
//  input_bias_ack  out  1          input_bias accepted in a cycle where input_bias_stb && input_bias_ack
//  output_y        out  [M][P][32] result matrix
//  output_y_stb    out  1          output_y valid
//  output_y_ack    in   1          consumer accepts output_y
// BEHAVIOUR
//  Reset (async, immediate): state=GET, output_y_stb=0, input_z_ack=0, input_bias_ack=0, output_y=0,
//   held flags/indices=0, adder instance reset. First ack rises on the first clk edge after rst deasserts.
//  GET: input_z_ack = !z_held, input_bias_ack = !bias_held. Each operand is latched independently on its
//   stb&&ack edge; its ack drops the next cycle. When both are held -> ISSUE with i=0, j=0.
//  ISSUE: drive adder a=z[i][j], b=bias[j], a_stb=b_stb=1; each stb drops once its adder ack is seen.
//   Both accepted -> WAIT.
//  WAIT: on adder z_stb assert adder z_ack for one cycle; write r to y[i][j], where
//   r = (RELU && sum[31]) ? 32'h0 : sum (includes -0 and negative NaN -> +0).
//   Index advance: j fastest, row-major. Last element (i=M-1, j=P-1) -> OUT, else -> ISSUE.
//  OUT: output_y_stb=1, output_y stable, both input acks 0. On output_y_ack=1: stb=0 next cycle,
//   held flags cleared -> GET.
//  Latency: GET exit to output_y_stb = M*P*(2 + adder latency) cycles. No overlap between frames.
//  Adder arithmetic: IEEE-754 single, round-to-nearest-even as per the adder sub-module; no extra
//   rounding or flushing in this block.
//  Boundary cases:
//   - Operand stb before the other: first operand is held, its ack stays low; nothing starts until both.
//   - Stb dropping without ack: ignored, no latch.
//   - output_y_ack high outside OUT: ignored.
//   - Reset mid-frame: result discarded, no partial output_y_stb, adder handshake cleared.
//   - M=1 or P=1: single-element rows/columns legal; index wrap still j fastest.
// STRUCTURE
//  linalg_pkg: typedef logic [31:0] float32_t; localparam FP_POS_ZERO = 32'h0;
//   enum {GET, ISSUE, WAIT, OUT} bias_relu_state_t.
//  One sub-module: adder (team single-precision adder, ports clk/rst/input_a/_stb/_ack,
//   input_b/_stb/_ack, output_z/_stb/_ack), one instance u_add. All other logic stays inline.
// TESTING
//  1 RELU=1, z=[22,28;49,64], bias=[1,2] -> y={41B80000,41F00000,42480000,42840000} ([23,30;50,66]).
//  2 RELU=1, same z, bias=[-30(C1F00000),0] -> y={00000000,41E00000,41980000,42800000} ([0,28;19,64]).
//  3 RELU=0, stimulus of 2 -> y[0][0]=C1000000 (-8), others as in 2.
//  4 output_y_ack=0 for 20 cycles in OUT -> stb stays 1, y stable, input acks 0;
//    ack pulse -> stb 0 next cycle, acks return in GET.
//  5 input_bias_stb 5 cycles after input_z_stb -> input_z_ack pulses once, no adder activity until the
//    bias is latched, result as in 1.
//  6 rst pulse mid-WAIT -> all outputs 0 same cycle, no stray output_y_stb; next frame gives case 1 result.

Source files
------------

// File: rtl/linalg_pkg.sv
// Shared types and float helpers for the linear-algebra blocks.
package linalg_pkg;

  typedef logic [31:0] float32_t;

  localparam float32_t FP_POS_ZERO = 32'h0000_0000;
  localparam float32_t FP_QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {GET, ISSUE, WAIT, OUT} bias_relu_state_t;
  typedef enum logic [1:0] {ADD_GET, ADD_CALC, ADD_PUT} add_state_t;

  // IEEE-754 single add, round-to-nearest-even, subnormals kept.
  // Mantissas carry 3 extra bits (guard, round, sticky) through align/normalise.
  function automatic float32_t fp_add(input float32_t a, input float32_t b);
    float32_t    hi, lo, r;
    logic [9:0]  e_hi, e_lo, e, d;
    logic [26:0] m_hi, m_lo, mask;
    logic [27:0] s;
    logic [24:0] rm;
    logic        st, up, a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    // order by magnitude so the subtraction below never goes negative
    if (a[30:0] >= b[30:0]) begin hi = a; lo = b; end
    else begin hi = b; lo = a; end
    e_hi = (hi[30:23] == 8'd0) ? 10'd1 : {2'b00, hi[30:23]};
    e_lo = (lo[30:23] == 8'd0) ? 10'd1 : {2'b00, lo[30:23]};
    m_hi = {hi[30:23] != 8'd0, hi[22:0], 3'b000};
    m_lo = {lo[30:23] != 8'd0, lo[22:0], 3'b000};
    d    = e_hi - e_lo;
    mask = '0;
    if (d >= 10'd27) begin
      st   = |m_lo;
      m_lo = {26'd0, st};
    end else begin
      mask = (27'd1 << d) - 27'd1;
      st   = |(m_lo & mask);
      m_lo = (m_lo >> d) | {26'd0, st};
    end
    if (hi[31] == lo[31]) s = {1'b0, m_hi} + {1'b0, m_lo};
    else                  s = {1'b0, m_hi} - {1'b0, m_lo};
    e = e_hi;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      // left-normalise, stopping at the subnormal exponent
      for (int k = 0; k < 26; k++) begin
        if (!s[26] && (e > 10'd1)) begin
          s = s << 1;
          e = e - 10'd1;
        end
      end
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    rm = {1'b0, s[26:3]} + {24'd0, up};
    if (rm[24]) begin
      rm = rm >> 1;
      e  = e + 10'd1;
    end
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) r = FP_QNAN;
    else if (a_inf)          r = a;
    else if (b_inf)          r = b;
    else if (s == 28'd0)     r = {a[31] & b[31], 31'd0};
    else if (e >= 10'd255)   r = {hi[31], 8'hFF, 23'd0};
    else if (!rm[23])        r = {hi[31], 8'd0, rm[22:0]};
    else                     r = {hi[31], e[7:0], rm[22:0]};
    return r;
  endfunction

endpackage

// File: rtl/mat_bias_relu_adder.sv
// Single-precision float adder with stb/ack handshakes on both operands and the result.
module adder
  import linalg_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  float32_t input_a,
  input  logic     input_a_stb,
  output logic     input_a_ack,
  input  float32_t input_b,
  input  logic     input_b_stb,
  output logic     input_b_ack,
  output float32_t output_z,
  output logic     output_z_stb,
  input  logic     output_z_ack
);

  add_state_t st_q;
  float32_t   a_q, b_q, z_q, sum_d;
  logic       a_held_q, b_held_q, z_stb_q;
  logic       a_take, b_take;

  assign input_a_ack  = (st_q == ADD_GET) && !a_held_q;
  assign input_b_ack  = (st_q == ADD_GET) && !b_held_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;

  // operand capture strobes and the combinational sum of the held operands
  always_comb begin
    a_take = input_a_stb && input_a_ack;
    b_take = input_b_stb && input_b_ack;
    sum_d  = fp_add(a_q, b_q);
  end

  // collect both operands, register the sum, hold it until acknowledged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= ADD_GET;
      a_q      <= '0;
      b_q      <= '0;
      z_q      <= '0;
      a_held_q <= 1'b0;
      b_held_q <= 1'b0;
      z_stb_q  <= 1'b0;
    end else begin
      case (st_q)
        ADD_GET: begin
          if (a_take) begin a_q <= input_a; a_held_q <= 1'b1; end
          if (b_take) begin b_q <= input_b; b_held_q <= 1'b1; end
          if ((a_held_q || a_take) && (b_held_q || b_take)) st_q <= ADD_CALC;
        end
        ADD_CALC: begin
          z_q     <= sum_d;
          z_stb_q <= 1'b1;
          st_q    <= ADD_PUT;
        end
        ADD_PUT: begin
          if (output_z_ack) begin
            z_stb_q  <= 1'b0;
            a_held_q <= 1'b0;
            b_held_q <= 1'b0;
            st_q     <= ADD_GET;
          end
        end
        default: st_q <= ADD_GET;
      endcase
    end
  end

endmodule

// File: rtl/mat_bias_relu.sv
// Adds a bias row to every row of an MxP float matrix, optional ReLU, using one serial adder.
module mat_bias_relu
  import linalg_pkg::*;
#(
  parameter int M    = 2,
  parameter int P    = 2,
  parameter bit RELU = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [M-1:0][P-1:0][31:0] input_z,
  input  logic                    input_z_stb,
  output logic                    input_z_ack,
  input  logic [P-1:0][31:0]      input_bias,
  input  logic                    input_bias_stb,
  output logic                    input_bias_ack,
  output logic [M-1:0][P-1:0][31:0] output_y,
  output logic                    output_y_stb,
  input  logic                    output_y_ack
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (P > 1) ? $clog2(P) : 1;

  bias_relu_state_t          st_q;
  logic [M-1:0][P-1:0][31:0] z_q, y_q;
  logic [P-1:0][31:0]        bias_q;
  logic [IW-1:0]             i_q;
  logic [JW-1:0]             j_q;
  logic z_held_q, b_held_q, z_ack_q, b_ack_q, y_stb_q;
  logic add_a_stb_q, add_b_stb_q, add_z_ack_q;

  float32_t add_a, add_b, add_z, res_d;
  logic     add_a_ack, add_b_ack, add_z_stb;
  logic     z_take, b_take, z_got, b_got, a_done, b_done, last_i, last_j;

  assign input_z_ack    = z_ack_q;
  assign input_bias_ack = b_ack_q;
  assign output_y       = y_q;
  assign output_y_stb   = y_stb_q;

  // handshake decode, current operands and the ReLU'd adder result
  always_comb begin
    z_take = input_z_stb && z_ack_q;
    b_take = input_bias_stb && b_ack_q;
    z_got  = z_held_q || z_take;
    b_got  = b_held_q || b_take;
    a_done = !add_a_stb_q || add_a_ack;
    b_done = !add_b_stb_q || add_b_ack;
    last_i = (i_q == IW'(M - 1));
    last_j = (j_q == JW'(P - 1));
    add_a  = z_q[i_q][j_q];
    add_b  = bias_q[j_q];
    // sign bit covers -0 and negative NaN as well
    res_d  = (RELU && add_z[31]) ? FP_POS_ZERO : add_z;
  end

  // frame sequencer: gather operands, walk elements row-major, present result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= GET;
      z_q         <= '0;
      bias_q      <= '0;
      y_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      z_held_q    <= 1'b0;
      b_held_q    <= 1'b0;
      z_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      y_stb_q     <= 1'b0;
      add_a_stb_q <= 1'b0;
      add_b_stb_q <= 1'b0;
      add_z_ack_q <= 1'b0;
    end else begin
      add_z_ack_q <= 1'b0;
      case (st_q)
        GET: begin
          if (z_take) begin z_q <= input_z;    z_held_q <= 1'b1; end
          if (b_take) begin bias_q <= input_bias; b_held_q <= 1'b1; end
          if (z_got && b_got) begin
            st_q        <= ISSUE;
            i_q         <= '0;
            j_q         <= '0;
            add_a_stb_q <= 1'b1;
            add_b_stb_q <= 1'b1;
            z_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
          end else begin
            z_ack_q <= !z_got;
            b_ack_q <= !b_got;
          end
        end
        ISSUE: begin
          if (add_a_stb_q && add_a_ack) add_a_stb_q <= 1'b0;
          if (add_b_stb_q && add_b_ack) add_b_stb_q <= 1'b0;
          if (a_done && b_done) st_q <= WAIT;
        end
        WAIT: begin
          if (add_z_stb && !add_z_ack_q) begin
            add_z_ack_q     <= 1'b1;
            y_q[i_q][j_q]   <= res_d;
            if (last_i && last_j) begin
              st_q    <= OUT;
              y_stb_q <= 1'b1;
            end else begin
              if (last_j) begin
                j_q <= '0;
                i_q <= i_q + IW'(1);
              end else begin
                j_q <= j_q + JW'(1);
              end
              add_a_stb_q <= 1'b1;
              add_b_stb_q <= 1'b1;
              st_q        <= ISSUE;
            end
          end
        end
        OUT: begin
          if (output_y_ack) begin
            y_stb_q  <= 1'b0;
            z_held_q <= 1'b0;
            b_held_q <= 1'b0;
            st_q     <= GET;
          end
        end
        default: st_q <= GET;
      endcase
    end
  end

  adder u_add (
    .clk          (clk),
    .rst          (rst),
    .input_a      (add_a),
    .input_a_stb  (add_a_stb_q),
    .input_a_ack  (add_a_ack),
    .input_b      (add_b),
    .input_b_stb  (add_b_stb_q),
    .input_b_ack  (add_b_ack),
    .output_z     (add_z),
    .output_z_stb (add_z_stb),
    .output_z_ack (add_z_ack_q)
  );

endmodule

// File: tb/tb_mat_bias_relu.sv
// Randomised + directed bench for mat_bias_relu; integer-valued floats give an exact reference.
module tb_mat_bias_relu;
  import linalg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][1:0][31:0] input_z;
  logic [1:0][31:0]      input_bias;
  logic input_z_stb, input_bias_stb, output_y_ack;
  logic z_ack1, b_ack1, ystb1, z_ack0, b_ack0, ystb0;
  logic [1:0][1:0][31:0] y1, y0;

  mat_bias_relu #(.M(2), .P(2), .RELU(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .input_z(input_z), .input_z_stb(input_z_stb), .input_z_ack(z_ack1),
    .input_bias(input_bias), .input_bias_stb(input_bias_stb), .input_bias_ack(b_ack1),
    .output_y(y1), .output_y_stb(ystb1), .output_y_ack(output_y_ack));

  mat_bias_relu #(.M(2), .P(2), .RELU(1'b0)) u0 (
    .clk(clk), .rst(rst),
    .input_z(input_z), .input_z_stb(input_z_stb), .input_z_ack(z_ack0),
    .input_bias(input_bias), .input_bias_stb(input_bias_stb), .input_bias_ack(b_ack0),
    .output_y(y0), .output_y_stb(ystb0), .output_y_ack(output_y_ack));

  int checks = 0, errors = 0;
  longint zv[2][2];
  longint bv[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // integer -> float32 bits, round-to-nearest-even
  function automatic logic [31:0] f32(input longint v);
    logic sgn;
    longint unsigned mag, keep, rem, half;
    int p, sh;
    if (v == 0) return 32'h0;
    sgn = (v < 0);
    mag = sgn ? longint'(-v) : longint'(v);
    p = 0;
    for (int k = 0; k < 48; k++) if ((mag >> k) != 0) p = k;
    if (p <= 23) keep = mag << (23 - p);
    else begin
      sh   = p - 23;
      keep = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep++;
      if (keep == (64'd1 << 24)) begin keep = keep >> 1; p++; end
    end
    return {sgn, 8'(127 + p), keep[22:0]};
  endfunction

  function automatic logic [31:0] ref_y(input int i, input int j, input bit relu);
    longint s = zv[i][j] + bv[j];
    if (relu && s < 0) return 32'h0;
    return f32(s);
  endfunction

  function automatic longint rnd_val();
    int bits = $urandom_range(0, 24);
    longint m = longint'($urandom) & ((longint'(1) << bits) - 1);
    if (m >= (longint'(1) << 24)) m = (longint'(1) << 24) - 1;
    return $urandom_range(0, 1) ? -m : m;
  endfunction

  // send one frame, optionally abort it with a reset once the sequencer is waiting on the adder
  task automatic run_frame(input int bias_dly, input int hold, input bit abort, input string tag);
    bit z_acc = 0, b_acc = 0, z_pend, b_pend, prev_zack = 0;
    int zp = 0, act = 0, cyc;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) input_z[i][j] = f32(zv[i][j]);
    for (int j = 0; j < 2; j++) input_bias[j] = f32(bv[j]);
    @(negedge clk);
    input_z_stb = 1'b1;
    if (bias_dly == 0) input_bias_stb = 1'b1;
    for (cyc = 0; cyc < 200 && !(z_acc && b_acc); cyc++) begin
      z_pend = input_z_stb && z_ack1;
      b_pend = input_bias_stb && b_ack1;
      if (z_ack1 && !prev_zack) zp++;
      prev_zack = z_ack1;
      if (!b_acc && u1.add_a_stb_q) act++;
      @(negedge clk);
      if (z_pend) begin input_z_stb = 1'b0; z_acc = 1; end
      if (b_pend) begin input_bias_stb = 1'b0; b_acc = 1; end
      if (cyc + 1 == bias_dly) input_bias_stb = 1'b1;
    end
    input_z_stb = 1'b0;
    input_bias_stb = 1'b0;
    chk({tag, " accepted"}, 32'({z_acc, b_acc}), 32'h3);
    if (bias_dly > 0) begin
      chk({tag, " zack pulses"}, 32'(zp), 32'd1);
      chk({tag, " early adder"}, 32'(act), 32'd0);
    end
    if (abort) begin
      cyc = 0;
      while (u1.st_q != WAIT && cyc < 100) begin @(negedge clk); cyc++; end
      chk({tag, " reach WAIT"}, 32'(cyc < 100), 32'd1);
      rst = 1'b1;
      #1;
      chk({tag, " rst stb"}, 32'({ystb1, ystb0}), 32'd0);
      chk({tag, " rst acks"}, 32'({z_ack1, b_ack1, z_ack0, b_ack0}), 32'd0);
      chk({tag, " rst y"}, 32'(y1 != '0 || y0 != '0), 32'd0);
      chk({tag, " rst adder z"}, 32'(u1.u_add.output_z_stb), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      zp = 0;
      for (int k = 0; k < 10; k++) begin @(negedge clk); if (ystb1 || ystb0) zp++; end
      chk({tag, " no stray stb"}, 32'(zp), 32'd0);
      return;
    end
    cyc = 0;
    while (!ystb1 && cyc < 500) begin @(negedge clk); cyc++; end
    chk({tag, " stb1"}, 32'(ystb1), 32'd1);
    chk({tag, " stb0"}, 32'(ystb0), 32'd1);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("%s relu y[%0d][%0d]", tag, i, j), y1[i][j], ref_y(i, j, 1'b1));
        chk($sformatf("%s pass y[%0d][%0d]", tag, i, j), y0[i][j], ref_y(i, j, 1'b0));
      end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold stb"}, 32'(ystb1), 32'd1);
      chk({tag, " hold acks"}, 32'({z_ack1, b_ack1}), 32'd0);
      chk({tag, " hold y00"}, y1[0][0], ref_y(0, 0, 1'b1));
    end
    output_y_ack = 1'b1;
    @(negedge clk);
    output_y_ack = 1'b0;
    chk({tag, " stb drop"}, 32'({ystb1, ystb0}), 32'd0);
    @(negedge clk);
    chk({tag, " acks back"}, 32'({z_ack1, b_ack1}), 32'h3);
  endtask

  task automatic set_case1();
    zv[0][0] = 22; zv[0][1] = 28; zv[1][0] = 49; zv[1][1] = 64;
    bv[0] = 1; bv[1] = 2;
  endtask

  initial begin
    rst = 1'b1;
    input_z = '0; input_bias = '0;
    input_z_stb = 1'b0; input_bias_stb = 1'b0; output_y_ack = 1'b0;
    #1;
    chk("reset stb", 32'({ystb1, ystb0}), 32'd0);
    chk("reset acks", 32'({z_ack1, b_ack1}), 32'd0);
    chk("reset y", 32'(y1 != '0), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("acks before edge", 32'({z_ack1, b_ack1}), 32'd0);
    @(negedge clk);
    chk("acks after edge", 32'({z_ack1, b_ack1}), 32'h3);

    set_case1();
    chk("spec c1 ref y00", ref_y(0, 0, 1'b1), 32'h41B80000);
    run_frame(0, 20, 1'b0, "case1");

    bv[0] = -30; bv[1] = 0;
    run_frame(0, 0, 1'b0, "case2");

    set_case1();
    run_frame(5, 0, 1'b0, "late bias");

    zv[0][0] = 16777216; zv[0][1] = 16777216; zv[1][0] = -16777216; zv[1][1] = 3;
    bv[0] = 1; bv[1] = 3;
    run_frame(0, 0, 1'b0, "rounding");

    zv[0][0] = 5; zv[0][1] = -7; zv[1][0] = 0; zv[1][1] = 0;
    bv[0] = -5; bv[1] = 7;
    run_frame(2, 0, 1'b0, "cancel");

    set_case1();
    run_frame(0, 0, 1'b1, "abort");
    run_frame(0, 0, 1'b0, "after abort");

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) zv[i][j] = rnd_val();
      for (int j = 0; j < 2; j++) bv[j] = rnd_val();
      if (n % 5 == 0) bv[0] = -zv[0][0];
      run_frame($urandom_range(0, 3), $urandom_range(0, 2), 1'b0, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
